// File: rtl/ste_avg_ctrl.sv
// Sequencer between the ADC sample stream and the ste_avg_iir averager:
// clear, settle-discard, forward, and decimate averager output to the display.
module ste_avg_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                SETTLE_N = 4,
    parameter int                FILL_N   = 16,
    parameter int                DISP_DIV = 8,
    parameter logic [DATA_W-1:0] OVR_TH   = 16'hFFF0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              adc_valid_i,
    input  logic              range_chg_i,
    input  logic              hold_i,
    output logic [DATA_W-1:0] avg_din_o,
    output logic              avg_en_o,
    output logic              avg_clr_o,
    input  logic [DATA_W-1:0] avg_dout_i,
    input  logic              avg_update_i,
    output logic [DATA_W-1:0] disp_data_o,
    output logic              disp_valid_o,
    output logic              settled_o,
    output logic              ovr_o
);

    localparam int SW = (SETTLE_N > 0) ? $clog2(SETTLE_N + 1) : 1;
    localparam int FW = $clog2(FILL_N + 1);
    localparam int DW = $clog2(DISP_DIV + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SETTLE = 3'd2,
        FILL   = 3'd3,
        RUN    = 3'd4
    } state_t;

    state_t        state_r;
    logic [SW-1:0] settle_cnt_r;
    logic [FW-1:0] fill_cnt_r;
    logic [DW-1:0] div_cnt_r;

    // Sequencer FSM with all outputs registered; range change overrides every other event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            settle_cnt_r <= '0;
            fill_cnt_r   <= '0;
            div_cnt_r    <= '0;
            avg_din_o    <= '0;
            avg_en_o     <= 1'b0;
            avg_clr_o    <= 1'b0;
            disp_data_o  <= '0;
            disp_valid_o <= 1'b0;
            settled_o    <= 1'b0;
            ovr_o        <= 1'b0;
        end else begin
            avg_en_o     <= 1'b0;
            avg_clr_o    <= 1'b0;
            disp_valid_o <= 1'b0;
            if (state_r == IDLE || range_chg_i) begin
                // Entering CLEAR: qualifiers and counters drop in the clear cycle itself.
                state_r      <= CLEAR;
                avg_clr_o    <= 1'b1;
                settled_o    <= 1'b0;
                ovr_o        <= 1'b0;
                settle_cnt_r <= '0;
                fill_cnt_r   <= '0;
                div_cnt_r    <= '0;
            end else begin
                case (state_r)
                    CLEAR: begin
                        state_r <= (SETTLE_N == 0) ? FILL : SETTLE;
                    end
                    SETTLE: begin
                        if (adc_valid_i) begin
                            if (settle_cnt_r == SW'(SETTLE_N - 1)) begin
                                state_r <= FILL;
                            end else begin
                                settle_cnt_r <= settle_cnt_r + SW'(1);
                            end
                        end
                    end
                    FILL, RUN: begin
                        if (adc_valid_i) begin
                            avg_en_o  <= 1'b1;
                            avg_din_o <= adc_data_i;
                            if (adc_data_i >= OVR_TH) begin
                                ovr_o <= 1'b1;
                            end
                        end
                        if (avg_update_i) begin
                            if (state_r == FILL) begin
                                if (fill_cnt_r == FW'(FILL_N - 1)) begin
                                    // Fill completion always publishes, regardless of hold.
                                    state_r      <= RUN;
                                    settled_o    <= 1'b1;
                                    disp_data_o  <= avg_dout_i;
                                    disp_valid_o <= 1'b1;
                                    div_cnt_r    <= '0;
                                end else begin
                                    fill_cnt_r <= fill_cnt_r + FW'(1);
                                end
                            end else if (div_cnt_r == DW'(DISP_DIV - 1)) begin
                                div_cnt_r <= '0;
                                if (!hold_i) begin
                                    disp_data_o  <= avg_dout_i;
                                    disp_valid_o <= 1'b1;
                                end
                            end else begin
                                div_cnt_r <= div_cnt_r + DW'(1);
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ste_avg_ctrl.sv
// Directed self-checking bench for ste_avg_ctrl; the bench itself plays the averager.
module tb_ste_avg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] adc_data_i;
    logic        adc_valid_i;
    logic        range_chg_i;
    logic        hold_i;
    logic [15:0] avg_din_o;
    logic        avg_en_o;
    logic        avg_clr_o;
    logic [15:0] avg_dout_i;
    logic        avg_update_i;
    logic [15:0] disp_data_o;
    logic        disp_valid_o;
    logic        settled_o;
    logic        ovr_o;

    int vectors = 0;
    int miscompares = 0;
    int pulses;
    int hits;

    ste_avg_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .adc_data_i   (adc_data_i),
        .adc_valid_i  (adc_valid_i),
        .range_chg_i  (range_chg_i),
        .hold_i       (hold_i),
        .avg_din_o    (avg_din_o),
        .avg_en_o     (avg_en_o),
        .avg_clr_o    (avg_clr_o),
        .avg_dout_i   (avg_dout_i),
        .avg_update_i (avg_update_i),
        .disp_data_o  (disp_data_o),
        .disp_valid_o (disp_valid_o),
        .settled_o    (settled_o),
        .ovr_o        (ovr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [15:0] d);
        adc_data_i  = d;
        adc_valid_i = 1'b1;
        step();
        adc_valid_i = 1'b0;
    endtask

    task automatic update(input logic [15:0] d);
        avg_dout_i   = d;
        avg_update_i = 1'b1;
        step();
        avg_update_i = 1'b0;
    endtask

    task automatic settle_then_forward(input string tag);
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            sample(16'd2000);
            if (avg_en_o) hits++;
        end
        chk({tag, "_settle_no_en"}, hits, 32'd0);
        sample(16'd2000);
        chk({tag, "_fwd_en"}, avg_en_o, 32'd1);
        chk({tag, "_fwd_din"}, avg_din_o, 32'd2000);
        step();
        chk({tag, "_en_single"}, avg_en_o, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; adc_data_i = '0; adc_valid_i = 1'b0; range_chg_i = 1'b0;
        hold_i = 1'b0; avg_dout_i = '0; avg_update_i = 1'b0;
        step(); step();
        chk("rst_outputs", {avg_en_o, avg_clr_o, disp_valid_o, settled_o, ovr_o}, 32'd0);
        chk("rst_data", {avg_din_o, disp_data_o}, 32'd0);

        // Reset release: exactly one clear cycle, right after the IDLE cycle.
        rst_n = 1'b1;
        step();
        chk("clr_first", avg_clr_o, 32'd1);
        step();
        chk("clr_one_cycle", avg_clr_o, 32'd0);

        // Settle: first strobe is an over-range value that must be discarded.
        hits = 0;
        sample(16'hFFFF);
        if (avg_en_o) hits++;
        for (int i = 0; i < 3; i++) begin
            sample(16'd2000);
            if (avg_en_o) hits++;
        end
        chk("settle_no_en", hits, 32'd0);
        chk("settle_no_ovr", ovr_o, 32'd0);
        sample(16'd2000);
        chk("fwd_en", avg_en_o, 32'd1);
        chk("fwd_din", avg_din_o, 32'd2000);
        step();
        chk("fwd_single", avg_en_o, 32'd0);

        // Fill: 15 updates leave the output unsettled, the 16th publishes.
        pulses = 0; hits = 0;
        for (int i = 0; i < 15; i++) begin
            update(16'd1234);
            if (disp_valid_o) pulses++;
            if (settled_o) hits++;
        end
        chk("fill_no_pulse", pulses, 32'd0);
        chk("fill_not_settled", hits, 32'd0);
        update(16'd1234);
        chk("fill_valid", disp_valid_o, 32'd1);
        chk("fill_data", disp_data_o, 32'd1234);
        chk("fill_settled", settled_o, 32'd1);
        step();
        chk("fill_valid_single", disp_valid_o, 32'd0);

        // Over-range on a forwarded sample.
        chk("ovr_before", ovr_o, 32'd0);
        sample(16'hFFF5);
        chk("ovr_fwd_en", avg_en_o, 32'd1);
        chk("ovr_fwd_din", avg_din_o, 32'hFFF5);
        chk("ovr_set", ovr_o, 32'd1);

        // Run decimation: pulses on updates 8, 16, 24 carrying that update's data.
        pulses = 0;
        for (int i = 1; i <= 24; i++) begin
            update(16'(100 + i));
            if (disp_valid_o) begin
                pulses++;
                chk("run_pulse_pos", 32'(i % 8), 32'd0);
                chk("run_pulse_data", disp_data_o, 32'(100 + i));
            end
        end
        chk("run_pulse_count", pulses, 32'd3);

        // Hold across 16 updates, then resume at the next wrap.
        hold_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            update(16'd777);
            if (disp_valid_o) pulses++;
        end
        chk("hold_no_pulse", pulses, 32'd0);
        chk("hold_data_kept", disp_data_o, 32'd124);
        hold_i = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            update(16'(500 + i));
            if (disp_valid_o) pulses++;
        end
        chk("resume_pulse", pulses, 32'd1);
        chk("resume_data", disp_data_o, 32'd508);
        chk("ovr_sticky", ovr_o, 32'd1);

        // Range change coincident with a sample and an update.
        adc_data_i = 16'd42; adc_valid_i = 1'b1; avg_update_i = 1'b1; range_chg_i = 1'b1;
        step();
        adc_valid_i = 1'b0; avg_update_i = 1'b0;
        chk("rc_no_en", avg_en_o, 32'd0);
        chk("rc_no_valid", disp_valid_o, 32'd0);
        chk("rc_clr", avg_clr_o, 32'd1);
        chk("rc_unsettled", settled_o, 32'd0);
        chk("rc_ovr_cleared", ovr_o, 32'd0);
        chk("rc_data_kept", disp_data_o, 32'd508);
        // Range change while clearing repeats the clear once.
        step();
        range_chg_i = 1'b0;
        chk("rc_second_clr", avg_clr_o, 32'd1);
        step();
        chk("rc_clr_done", avg_clr_o, 32'd0);
        settle_then_forward("rc");

        // Refill to RUN, set over-range, then pull reset mid-operation.
        for (int i = 0; i < 16; i++) update(16'd900);
        chk("refill_settled", settled_o, 32'd1);
        sample(16'hFFF5);
        chk("pre_rst_en", avg_en_o, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {avg_en_o, avg_clr_o, disp_valid_o, settled_o, ovr_o}, 32'd0);
        chk("async_rst_data", {avg_din_o, disp_data_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
